// File: rtl/control_unit.sv
// Hardwired Moore sequencer for a fetch/decode/execute datapath: T0..T5 plus HALT.
// Optional macro CU_MEM_WAIT_EN stretches T1 until MemReady is sampled high.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [31:0]      IR,
  input  logic             MemReady,
  output logic             PCout,
  output logic             MDRout,
  output logic             Zhiout,
  output logic             Zlowout,
  output logic             MARin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             PCin,
  output logic             IncPC,
  output logic             Read,
  output logic             ADD,
  output logic             SUB,
  output logic             AND,
  output logic             OR,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             Run,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       opcode;
  logic             is_alu;
  logic             is_halt;

  assign opcode  = IR[31:27];
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_halt = (opcode == OP_HALT);

`ifdef CU_MEM_WAIT_EN
  logic unused_ir;
  assign unused_ir = ^IR[26:0];
`else
  logic unused_ir;
  assign unused_ir = ^{IR[26:0], MemReady};
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_T0: state_d = S_T1;
`ifdef CU_MEM_WAIT_EN
      S_T1: state_d = MemReady ? S_T2 : S_T1;
`else
      S_T1: state_d = S_T2;
`endif
      S_T2: begin
        if (is_alu) begin
          state_d = S_T3;
        end else begin
          // nop retires here; halt counts as retired on entry to HALT
          state_d = is_halt ? S_HALT : S_T0;
          count_d = count_q + CNT_W'(1);
        end
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        state_d = S_T0;
        count_d = count_q + CNT_W'(1);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_T0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Clear gates outputs combinationally so strobes drop in the same cycle it rises.
  always_comb begin
    PCout   = 1'b0;
    MDRout  = 1'b0;
    Zhiout  = 1'b0;
    Zlowout = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    ADD     = 1'b0;
    SUB     = 1'b0;
    AND     = 1'b0;
    OR      = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    if (!Clear) begin
      case (state_q)
        S_T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
        end
        S_T1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
        S_T4: begin
          Grc  = 1'b1;
          Rout = 1'b1;
          Zin  = 1'b1;
          ADD  = (opcode == OP_ADD);
          SUB  = (opcode == OP_SUB);
          AND  = (opcode == OP_AND);
          OR   = (opcode == OP_OR);
        end
        S_T5: begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Run        = !Clear && (state_q != S_HALT);
  assign InstrCount = Clear ? '0 : count_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction
// streams compared cycle by cycle against an instruction-level reference model.
module tb_control_unit;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;
`ifdef CU_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [21:0] M_PCOUT   = 22'h1 << 21;
  localparam logic [21:0] M_MDROUT  = 22'h1 << 20;
  localparam logic [21:0] M_ZLOWOUT = 22'h1 << 18;
  localparam logic [21:0] M_MARIN   = 22'h1 << 17;
  localparam logic [21:0] M_MDRIN   = 22'h1 << 16;
  localparam logic [21:0] M_IRIN    = 22'h1 << 15;
  localparam logic [21:0] M_YIN     = 22'h1 << 14;
  localparam logic [21:0] M_ZIN     = 22'h1 << 13;
  localparam logic [21:0] M_INCPC   = 22'h1 << 11;
  localparam logic [21:0] M_READ    = 22'h1 << 10;
  localparam logic [21:0] M_ADD     = 22'h1 << 9;
  localparam logic [21:0] M_SUB     = 22'h1 << 8;
  localparam logic [21:0] M_AND     = 22'h1 << 7;
  localparam logic [21:0] M_OR      = 22'h1 << 6;
  localparam logic [21:0] M_GRA     = 22'h1 << 5;
  localparam logic [21:0] M_GRB     = 22'h1 << 4;
  localparam logic [21:0] M_GRC     = 22'h1 << 3;
  localparam logic [21:0] M_RIN     = 22'h1 << 2;
  localparam logic [21:0] M_ROUT    = 22'h1 << 1;
  localparam logic [21:0] M_RUN     = 22'h1;

  logic             Clock, Clear, MemReady;
  logic [31:0]      IR;
  logic             PCout, MDRout, Zhiout, Zlowout, MARin, MDRin, IRin, Yin, Zin, PCin;
  logic             IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc, Rin, Rout, Run;
  logic [CNT_W-1:0] InstrCount;
  logic [21:0]      obs;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt = 0;

  control_unit #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .MDRout(MDRout), .Zhiout(Zhiout), .Zlowout(Zlowout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin),
    .IncPC(IncPC), .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Run(Run),
    .InstrCount(InstrCount)
  );

  assign obs = {PCout, MDRout, Zhiout, Zlowout, MARin, MDRin, IRin, Yin, Zin, PCin,
                IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc, Rin, Rout, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Inputs change at the falling edge; outputs are observed 1 time unit later.
  task automatic step(input bit clr, input logic [31:0] ir, input bit mr);
    @(negedge Clock);
    Clear    = clr;
    IR       = ir;
    MemReady = mr;
    #1;
  endtask

  task automatic check(input string tag, input logic [21:0] exp);
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = CNT_W'(model_cnt % CNT_MOD);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s strobes got %h want %h", tag, obs, exp);
    end
    vectors++;
    assert (InstrCount === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s InstrCount got %0d want %0d", tag, InstrCount, exp_cnt);
    end
    $display("%-6s IR=%h strobes=%h cnt=%0d", tag, IR, obs, InstrCount);
  endtask

  function automatic logic [21:0] alu_sel(input logic [4:0] op);
    case (op)
      5'd3:    return M_ADD;
      5'd4:    return M_SUB;
      5'd5:    return M_AND;
      5'd6:    return M_OR;
      default: return 22'h0;
    endcase
  endfunction

  // One instruction from T0. stall >= 0 gives the number of MemReady-low cycles in T1
  // (negative: random). abort_at 3..5 asserts Clear in that execute phase instead.
  task automatic run_instr(input logic [31:0] ir, input int stall, input int abort_at);
    logic [4:0]  op;
    logic [21:0] exec_words[3];
    bit          mr;
    int          n;
    op = ir[31:27];
    step(1'b0, ir, 1'($urandom_range(0, 1)));
    check("T0", M_PCOUT | M_MARIN | M_INCPC | M_RUN);
    n = 0;
    do begin
      if (stall >= 0) mr = (n >= stall);
      else            mr = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b0, ir, mr);
      check("T1", M_READ | M_MDRIN | M_RUN);
      n++;
    end while (WAIT_EN && !mr);
    step(1'b0, ir, 1'($urandom_range(0, 1)));
    check("T2", M_MDROUT | M_IRIN | M_RUN);
    if (alu_sel(op) != 22'h0) begin
      exec_words[0] = M_GRB | M_ROUT | M_YIN | M_RUN;
      exec_words[1] = M_GRC | M_ROUT | M_ZIN | alu_sel(op) | M_RUN;
      exec_words[2] = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
      for (int k = 0; k < 3; k++) begin
        if (abort_at == k + 3) begin
          step(1'b1, ir, 1'b0);
          model_cnt = 0;
          check("CLRMID", 22'h0);
          return;
        end
        step(1'b0, ir, 1'($urandom_range(0, 1)));
        check($sformatf("T%0d", k + 3), exec_words[k]);
      end
      model_cnt++;
    end else if (op == 5'b11011) begin
      model_cnt++;
      for (int k = 0; k < 20; k++) begin
        step(1'b0, ir, 1'($urandom_range(0, 1)));
        check("HALT", 22'h0);
      end
    end else begin
      model_cnt++;
    end
  endtask

  initial begin
    Clear = 1'b1; IR = 32'h0; MemReady = 1'b0;
    // Two cycles of Clear: everything low, counter reads zero.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h198B8000, 1'b0);
      model_cnt = 0;
      check("CLR", 22'h0);
    end
    run_instr(32'h198B8000, 0, -1);
    for (int k = 0; k < 3; k++) run_instr(32'hD0000000, 0, -1);
    run_instr(32'h198B8000, 3, -1);
    run_instr({5'b00100, 27'h0123456}, 0, 4);
    run_instr({5'b00101, 27'h7654321}, -1, -1);
    run_instr({5'b00110, 27'h0F0F0F0}, -1, -1);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      r = $urandom;
      if (r[31:27] == 5'b11011) r[31:27] = 5'b11010;
      run_instr(r, -1, -1);
    end
    run_instr(32'hD8000000, 0, -1);
    step(1'b1, 32'hD8000000, 1'b0);
    model_cnt = 0;
    check("CLR", 22'h0);
    run_instr(32'h198B8000, -1, -1);
    run_instr({5'b11010, 27'h1}, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001: Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002: Clock  input  1  system clock; all state changes on rising edge.
REQ-003: Clear  input  1  reset, synchronous and active-high.
REQ-004: IR  input  32  current instruction word from the datapath IR; opcode is IR[31:27].
REQ-005: MemReady  input  1  memory read-complete handshake; used only when CU_MEM_WAIT_EN is defined.
REQ-006: PCout, MDRout, Zhiout, Zlowout  output  1 each  bus-drive strobes to the datapath.
REQ-007: MARin, MDRin, IRin, Yin, Zin, PCin  output  1 each  register-load strobes.
REQ-008: IncPC, Read  output  1 each  PC increment and memory read strobes.
REQ-009: ADD, SUB, AND, OR  output  1 each  ALU operation selects, one-hot or all zero.
REQ-010: Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and general-register in/out strobes.
REQ-011: Run  output  1  high while the sequencer is executing; low in HALT and during Clear.
REQ-012: InstrCount  output  CNT_W  count of completed instructions.

Function
REQ-013: Moore FSM with states T0, T1, T2, T3, T4, T5, HALT; all strobes decode from the current state and IR only.
REQ-014: T0 asserts PCout, MARin and IncPC, then goes to T1.
REQ-015: T1 asserts Read and MDRin, then goes to T2 (see REQ-026 for the wait variant).
REQ-016: T2 asserts MDRout and IRin; next state is decoded from the IR value present during T2.
REQ-017: Opcodes: 00011 = add, 00100 = sub, 00101 = and, 00110 = or, 11011 = halt; all other opcodes, including 11010, are nop.
REQ-018: For ALU opcodes, T2 goes to T3; for nop, T2 goes to T0; for halt, T2 goes to HALT.
REQ-019: T3 asserts Grb, Rout and Yin.
REQ-020: T4 asserts Grc, Rout, Zin and exactly one ALU select matching the opcode.
REQ-021: T5 asserts Zlowout, Gra and Rin, then goes to T0.
REQ-022: Each strobe not listed for a state is 0 in that state; no two bus-drive strobes (PCout, MDRout, Zhiout, Zlowout, Rout) are ever high together.
REQ-023: InstrCount increments by 1 on leaving T5, on a nop leaving T2, and on entering HALT; it wraps from 2^CNT_W-1 to 0.
REQ-024: HALT drives all strobes to 0 and Run to 0, and holds until Clear.

Reset
REQ-025: While Clear is sampled high, the next state is T0 and InstrCount is 0; during Clear, every strobe output and Run are forced to 0. Clear overrides every state, including mid-instruction and HALT. The first T0 strobes appear in the first cycle after Clear is deasserted.

Configuration
REQ-026: With CU_MEM_WAIT_EN defined, T1 holds (Read and MDRin stay high) until MemReady is sampled high, then goes to T2. Without it, T1 lasts exactly one cycle and MemReady is ignored. The MemReady port exists in both builds.

Verification
REQ-027: Clear high for 2 cycles, then low -> all outputs 0 and InstrCount=0 during Clear; PCout=MARin=IncPC=1 in the first cycle after.
REQ-028: IR=0x198B8000 (add R3,R1,R7) -> six-cycle sequence T0..T5; ADD=1 only in T4; InstrCount=1 after T5; next cycle is T0.
REQ-029: IR=0xD0000000 (nop) -> T0,T1,T2,T0 loop; InstrCount +1 per 3 cycles; Yin, Zin and Rin never assert.
REQ-030: IR=0xD8000000 (halt) -> HALT after T2, Run=0 and all strobes 0 for 20 cycles; a Clear pulse returns to T0.
REQ-031: CU_MEM_WAIT_EN defined, MemReady low for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles; T2 on the cycle after MemReady=1.
REQ-032: Assert Clear during T4 of a sub instruction -> SUB and Zin drop immediately; T0 follows Clear release, and InstrCount=0.
